// File: rtl/block_data_ctrl_pkg.sv
// Shared types and helpers for the tile fetch/unpack controller.
// Element (0,0) of a packed tile sits in the most significant WIDTH bits.
package block_data_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_e;

  localparam int WIDTH_DEF = 16;
  localparam int BLK_DEF   = 4;
  localparam int TILE_W    = WIDTH_DEF * BLK_DEF * BLK_DEF;

  // Index width that never collapses to zero bits for single-entry dimensions.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [WIDTH_DEF-1:0] extract(input logic [TILE_W-1:0] tile,
                                                    input int r, input int c);
    return tile[TILE_W-1-WIDTH_DEF*(r*BLK_DEF+c) -: WIDTH_DEF];
  endfunction

endpackage

// File: rtl/block_data_ctrl_tile_counter.sv
// Row/column walker over the tile grid; *_d outputs expose the value the
// counters take at the next edge so the fetch address can be registered.
module block_data_ctrl_tile_counter
  import block_data_ctrl_pkg::*;
#(
  parameter int NUM_ROWS      = 4,
  parameter int TILES_PER_ROW = 16,
  localparam int RW = idx_w(NUM_ROWS),
  localparam int CW = idx_w(TILES_PER_ROW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          advance,
  output logic [RW-1:0] row_q,
  output logic [CW-1:0] col_q,
  output logic [RW-1:0] row_d,
  output logic [CW-1:0] col_d,
  output logic          row_last,
  output logic          all_last
);

  assign row_last = (col_q == CW'(TILES_PER_ROW - 1));
  assign all_last = row_last && (row_q == RW'(NUM_ROWS - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (row_last) begin
        col_d = '0;
        row_d = all_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/block_data_ctrl.sv
// Tile fetch/unpack controller: one RAM read per tile, holds the tile for the
// MAC until done_accum, then moves on. All outputs are registered.
module block_data_ctrl
  import block_data_ctrl_pkg::*;
#(
  parameter int               WIDTH         = 16,
  parameter int               BLK           = 4,
  parameter int               TILES_PER_ROW = 16,
  parameter int               NUM_ROWS      = 4,
  parameter int               ADDR_W        = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int               RD_LAT        = 1,
  localparam int TW = WIDTH * BLK * BLK,
  localparam int RW = idx_w(NUM_ROWS),
  localparam int CW = idx_w(TILES_PER_ROW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [TW-1:0]     ram_data,
  output logic [TW-1:0]     tile_data,
  output logic              tile_valid,
  input  logic              done_accum,
  output logic [RW-1:0]     row_idx,
  output logic [CW-1:0]     col_idx,
  output logic              row_done,
  output logic              done,
  output logic              busy
);

  localparam int WAIT_W = idx_w(RD_LAT);
  localparam int AW1    = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              ram_en_q, ram_en_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [TW-1:0]     tile_q, tile_d;
  logic              tile_valid_q, tile_valid_d;
  logic [RW-1:0]     row_idx_q, row_idx_d;
  logic [CW-1:0]     col_idx_q, col_idx_d;
  logic              row_done_q, row_done_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              cnt_clr, cnt_adv, row_last, all_last;
  logic [RW-1:0]     cnt_row, cnt_row_nxt;
  logic [CW-1:0]     cnt_col, cnt_col_nxt;
  logic [AW1-1:0]    addr_full;

  block_data_ctrl_tile_counter #(
    .NUM_ROWS     (NUM_ROWS),
    .TILES_PER_ROW(TILES_PER_ROW)
  ) u_tile_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .advance (cnt_adv),
    .row_q   (cnt_row),
    .col_q   (cnt_col),
    .row_d   (cnt_row_nxt),
    .col_d   (cnt_col_nxt),
    .row_last(row_last),
    .all_last(all_last)
  );

  // Address of the tile the counters point at after this edge; wraps silently.
  assign addr_full = AW1'(BASE_ADDR) + AW1'(cnt_row_nxt) * AW1'(TILES_PER_ROW)
                   + AW1'(cnt_col_nxt);

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    tile_d     = tile_q;
    row_idx_d  = row_idx_q;
    col_idx_d  = col_idx_q;
    row_done_d = 1'b0;
    done_d     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_adv    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (start) state_d = S_REQ;
      end
      S_REQ: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == WAIT_W'(RD_LAT - 1)) begin
          tile_d    = ram_data;
          row_idx_d = cnt_row;
          col_idx_d = cnt_col;
          state_d   = S_HOLD;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_HOLD: begin
        if (done_accum) begin
          cnt_adv    = 1'b1;
          row_done_d = row_last;
          done_d     = all_last;
          state_d    = all_last ? S_DONE : S_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ram_en_d     = (state_d == S_REQ);
    ram_addr_d   = ram_en_d ? ADDR_W'(addr_full) : ram_addr_q;
    tile_valid_d = (state_d == S_HOLD);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wait_q       <= '0;
      ram_en_q     <= 1'b0;
      ram_addr_q   <= '0;
      tile_q       <= '0;
      tile_valid_q <= 1'b0;
      row_idx_q    <= '0;
      col_idx_q    <= '0;
      row_done_q   <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      ram_en_q     <= ram_en_d;
      ram_addr_q   <= ram_addr_d;
      tile_q       <= tile_d;
      tile_valid_q <= tile_valid_d;
      row_idx_q    <= row_idx_d;
      col_idx_q    <= col_idx_d;
      row_done_q   <= row_done_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_addr   = ram_addr_q;
  assign tile_data  = tile_q;
  assign tile_valid = tile_valid_q;
  assign row_idx    = row_idx_q;
  assign col_idx    = col_idx_q;
  assign row_done   = row_done_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_block_data_ctrl.sv
// Bench for block_data_ctrl: default config plus a small RD_LAT=3 config,
// each with a latency-accurate RAM model feeding a tile scoreboard.
`timescale 1ns/1ps
module tb_block_data_ctrl;
  import block_data_ctrl_pkg::*;

  localparam int TWB = 256;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic            start_s[2];
  logic            da_s[2];
  logic            ram_en_s[2];
  logic [15:0]     ram_addr_s[2];
  logic [TWB-1:0]  tile_data_s[2];
  logic            tile_valid_s[2];
  int              row_idx_s[2];
  int              col_idx_s[2];
  logic            row_done_s[2];
  logic            done_s[2];
  logic            busy_s[2];
  int              n_reads_s[2];
  int              n_done_s[2];
  int              n_rowdone_s[2];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [TWB-1:0] got, input logic [TWB-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [TWB-1:0] rand_word();
    logic [TWB-1:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int          RD   = (g == 0) ? 1 : 3;
    localparam logic [15:0] BASE = (g == 0) ? 16'h0000 : 16'h0100;
    localparam int          TPR  = (g == 0) ? 16 : 2;
    localparam int          NR   = (g == 0) ? 4 : 2;
    localparam int          NT   = TPR * NR;
    localparam int          RW   = (NR > 1) ? $clog2(NR) : 1;
    localparam int          CW   = (TPR > 1) ? $clog2(TPR) : 1;

    logic           ram_en, tile_valid, row_done, done, busy;
    logic [15:0]    ram_addr;
    logic [TWB-1:0] ram_data = '0;
    logic [TWB-1:0] tile_data;
    logic [RW-1:0]  row_idx;
    logic [CW-1:0]  col_idx;

    block_data_ctrl #(
      .WIDTH(16), .BLK(4), .TILES_PER_ROW(TPR), .NUM_ROWS(NR),
      .ADDR_W(16), .BASE_ADDR(BASE), .RD_LAT(RD)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_s[g]),
      .ram_en(ram_en), .ram_addr(ram_addr), .ram_data(ram_data),
      .tile_data(tile_data), .tile_valid(tile_valid), .done_accum(da_s[g]),
      .row_idx(row_idx), .col_idx(col_idx),
      .row_done(row_done), .done(done), .busy(busy)
    );

    logic [TWB-1:0] exp_q[$];
    int row_q[$], col_q[$], en_cyc_q[$], pipe_q[$];
    int k = 0, cyc = 0, a = 0, lat = 0;
    int n_reads = 0, n_done = 0, n_rowdone = 0;
    logic exp_rd = 1'b0, exp_dn = 1'b0, prev_valid = 1'b0;

    assign ram_en_s[g]     = ram_en;
    assign ram_addr_s[g]   = ram_addr;
    assign tile_data_s[g]  = tile_data;
    assign tile_valid_s[g] = tile_valid;
    assign row_idx_s[g]    = int'(row_idx);
    assign col_idx_s[g]    = int'(col_idx);
    assign row_done_s[g]   = row_done;
    assign done_s[g]       = done;
    assign busy_s[g]       = busy;
    assign n_reads_s[g]    = n_reads;
    assign n_done_s[g]     = n_done;
    assign n_rowdone_s[g]  = n_rowdone;

    // Monitor plus RAM model: data appears in the cycle RD after the read.
    always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
        exp_q.delete(); row_q.delete(); col_q.delete();
        en_cyc_q.delete(); pipe_q.delete();
        k = 0; exp_rd = 1'b0; exp_dn = 1'b0; prev_valid = 1'b0;
      end else begin
        if (exp_rd || row_done) check("row_done", row_done, exp_rd);
        if (exp_dn || done) check("done", done, exp_dn);
        if (row_done) n_rowdone++;
        if (done) n_done++;
        if (tile_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            check("tile_unexpected", 1, 0);
          end else begin
            check("tile_data", tile_data, exp_q.pop_front());
            check("row_idx", row_idx, row_q.pop_front());
            check("col_idx", col_idx, col_q.pop_front());
            lat = cyc - en_cyc_q.pop_front();
            check("valid_latency", lat, RD + 1);
          end
        end
        if (ram_en) begin
          check("ram_addr", ram_addr, 16'(int'(BASE) + k));
          check("en_while_valid", tile_valid, 0);
          row_q.push_back(k / TPR);
          col_q.push_back(k % TPR);
          en_cyc_q.push_back(cyc);
          n_reads++;
          k = (k + 1) % NT;
        end
        exp_rd = tile_valid && da_s[g] && (int'(col_idx) == TPR - 1);
        exp_dn = exp_rd && (int'(row_idx) == NR - 1);
        prev_valid = tile_valid;
        pipe_q.push_back(ram_en ? int'(ram_addr) : -1);
        ram_data = rand_word();
        if (pipe_q.size() > RD) begin
          a = pipe_q.pop_front();
          if (a >= 0) exp_q.push_back(ram_data);
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    check({tag, "_ram_en"}, ram_en_s[0], 0);
    check({tag, "_ram_addr"}, ram_addr_s[0], 0);
    check({tag, "_tile_data"}, tile_data_s[0], 0);
    check({tag, "_tile_valid"}, tile_valid_s[0], 0);
    check({tag, "_row_idx"}, row_idx_s[0], 0);
    check({tag, "_col_idx"}, col_idx_s[0], 0);
    check({tag, "_row_done"}, row_done_s[0], 0);
    check({tag, "_done"}, done_s[0], 0);
    check({tag, "_busy"}, busy_s[0], 0);
  endtask

  task automatic finish_walk(input int g, input string tag, input int r0, input int d0,
                             input int rd0, input int exp_reads, input int exp_rows);
    repeat (3) step();
    check({tag, "_reads"}, n_reads_s[g] - r0, exp_reads);
    check({tag, "_done_cnt"}, n_done_s[g] - d0, 1);
    check({tag, "_row_done_cnt"}, n_rowdone_s[g] - rd0, exp_rows);
    check({tag, "_idle"}, busy_s[g], 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0, rd0, bud, bp;
    logic seen_en, seen_tile;
    logic [TWB-1:0] held, w;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      da_s[i]    = 1'b0;
    end
    repeat (3) step();
    chk_zero("rst");
    rst_n = 1'b1;
    step();

    // Full walk, done_accum high, stray start pulses while busy.
    r0 = n_reads_s[0]; d0 = n_done_s[0]; rd0 = n_rowdone_s[0];
    da_s[0] = 1'b1; start_s[0] = 1'b1;
    step();
    bud = 2000;
    while (!done_s[0] && bud > 0) begin
      start_s[0] = 1'($urandom_range(0, 1));
      step();
      bud--;
    end
    start_s[0] = 1'b0;
    check("walk1_done", done_s[0], 1);
    finish_walk(0, "walk1", r0, d0, rd0, 64, 4);

    // Element extraction.
    w = '0;
    for (int e = 0; e < 16; e++) w = {w[TWB-17:0], 16'(16'h0100 + e)};
    check("extract_0_0", extract(w, 0, 0), 16'h0100);
    check("extract_1_2", extract(w, 1, 2), 16'h0106);
    check("extract_3_3", extract(w, 3, 3), 16'h010F);

    // Backpressure on tile 5, random done_accum elsewhere (incl. REQ/WAIT).
    r0 = n_reads_s[0]; d0 = n_done_s[0]; rd0 = n_rowdone_s[0];
    start_s[0] = 1'b1;
    step();
    start_s[0] = 1'b0;
    bud = 4000; bp = 0; held = '0;
    while (!done_s[0] && bud > 0) begin
      if (tile_valid_s[0] && row_idx_s[0] == 0 && col_idx_s[0] == 5 && bp < 10) begin
        if (bp == 0) begin
          held = tile_data_s[0];
        end else begin
          check("bp_data", tile_data_s[0], held);
          check("bp_col", col_idx_s[0], 5);
          check("bp_ram_en", ram_en_s[0], 0);
        end
        da_s[0] = 1'b0;
        bp++;
      end else begin
        da_s[0] = 1'($urandom_range(0, 1));
      end
      step();
      bud--;
    end
    check("bp_reached", bp, 10);
    check("bp_done", done_s[0], 1);
    da_s[0] = 1'b1;
    finish_walk(0, "bp", r0, d0, rd0, 64, 4);

    // Asynchronous reset while holding tile 7, then a clean restart.
    start_s[0] = 1'b1;
    step();
    start_s[0] = 1'b0;
    bud = 500;
    while (!(tile_valid_s[0] && col_idx_s[0] == 7) && bud > 0) begin
      step();
      bud--;
    end
    check("arst_reach", tile_valid_s[0], 1);
    da_s[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("arst");
    step();
    step();
    rst_n = 1'b1;
    step();
    check("arst_stays_idle", busy_s[0], 0);
    r0 = n_reads_s[0]; d0 = n_done_s[0]; rd0 = n_rowdone_s[0];
    da_s[0] = 1'b1; start_s[0] = 1'b1;
    step();
    start_s[0] = 1'b0;
    bud = 2000; seen_en = 1'b0; seen_tile = 1'b0;
    while (!done_s[0] && bud > 0) begin
      if (ram_en_s[0] && !seen_en) begin
        check("restart_addr", ram_addr_s[0], 0);
        seen_en = 1'b1;
      end
      if (tile_valid_s[0] && !seen_tile) begin
        check("restart_row", row_idx_s[0], 0);
        check("restart_col", col_idx_s[0], 0);
        seen_tile = 1'b1;
      end
      step();
      bud--;
    end
    check("restart_done", done_s[0], 1);
    finish_walk(0, "restart", r0, d0, rd0, 64, 4);

    // start held through DONE: exactly one follow-on walk.
    r0 = n_reads_s[0];
    start_s[0] = 1'b1;
    step();
    bud = 2000;
    while (!done_s[0] && bud > 0) begin
      step();
      bud--;
    end
    check("held_done", done_s[0], 1);
    check("held_reads", n_reads_s[0] - r0, 64);
    step();
    check("held_idle_gap", busy_s[0], 0);
    r0 = n_reads_s[0]; d0 = n_done_s[0]; rd0 = n_rowdone_s[0];
    step();
    check("held_rewalk_en", ram_en_s[0], 1);
    check("held_rewalk_addr", ram_addr_s[0], 0);
    start_s[0] = 1'b0;
    bud = 2000;
    while (!done_s[0] && bud > 0) begin
      step();
      bud--;
    end
    check("held_done2", done_s[0], 1);
    finish_walk(0, "held2", r0, d0, rd0, 64, 4);
    repeat (5) step();
    check("held_no_third", busy_s[0], 0);

    // Small grid, RD_LAT=3, non-zero base.
    r0 = n_reads_s[1]; d0 = n_done_s[1]; rd0 = n_rowdone_s[1];
    da_s[1] = 1'b1; start_s[1] = 1'b1;
    step();
    start_s[1] = 1'b0;
    bud = 200;
    while (!done_s[1] && bud > 0) begin
      step();
      bud--;
    end
    check("cfgb_done", done_s[1], 1);
    finish_walk(1, "cfgb", r0, d0, rd0, 4, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
